// File: rtl/conv_param_loader_if.sv
// Byte-stream handshake plus weight/bias memory write ports of the conv parameter loader.
// slave = loader side, master = host/memory side.
`ifndef PARSIZE
`define PARSIZE 16
`endif

interface conv_param_loader_if #(
    parameter int TAPS    = 9,
    parameter int PARSIZE = `PARSIZE
);
    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    wr_w_en;
    logic [11:0]             wr_w_addr;
    logic [TAPS*PARSIZE-1:0] wr_w_data;
    logic                    wr_b_en;
    logic [6:0]              wr_b_addr;
    logic [PARSIZE-1:0]      wr_b_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_w_en, wr_w_addr, wr_w_data, wr_b_en, wr_b_addr, wr_b_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_w_en, wr_w_addr, wr_w_data, wr_b_en, wr_b_addr, wr_b_data
    );
endinterface

// File: rtl/conv_param_loader.sv
// Streams little-endian 16-bit parameters into the conv weight rows and bias entries.
// Optional PARAM_CHECKSUM_EN: one trailing byte checked against the mod-256 sum of the stream.
`ifndef PARSIZE
`define PARSIZE 16
`endif

module conv_param_loader #(
    parameter int W_ROWS = 2576,
    parameter int B_ROWS = 112,
    parameter int TAPS   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    conv_param_loader_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int PW = `PARSIZE;

`ifdef PARAM_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_WEIGHT, S_BIAS, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WEIGHT, S_BIAS, S_DONE} state_t;
`endif

    state_t                 state_reg, state_next;
    logic                   hi_phase_reg;
    logic [7:0]             lo_byte_reg;
    logic [3:0]             tap_cnt_reg;
    logic [11:0]            row_cnt_reg;
    logic [6:0]             bias_cnt_reg;
    logic [(TAPS-1)*PW-1:0] row_buf_reg;
    logic                   wr_w_en_reg, wr_b_en_reg;
    logic [11:0]            wr_w_addr_reg;
    logic [TAPS*PW-1:0]     wr_w_data_reg;
    logic [6:0]             wr_b_addr_reg;
    logic [PW-1:0]          wr_b_data_reg;
    logic                   err_reg;

    logic          accept;
    logic          load_start;
    logic          tap_last, row_last, bias_last;
    logic [PW-1:0] word;

    assign accept     = bus.in_valid && bus.in_ready;
    assign load_start = start && (state_reg == S_IDLE || state_reg == S_DONE);
    assign tap_last   = (tap_cnt_reg == 4'(TAPS - 1));
    assign row_last   = (row_cnt_reg == 12'(W_ROWS - 1));
    assign bias_last  = (bias_cnt_reg == 7'(B_ROWS - 1));
    assign word       = {bus.in_data, lo_byte_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                done = (state_reg == S_DONE);
                if (start) state_next = S_WEIGHT;
            end
            S_WEIGHT: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (accept && hi_phase_reg && tap_last && row_last) state_next = S_BIAS;
            end
            S_BIAS: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (accept && hi_phase_reg && bias_last) begin
`ifdef PARAM_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef PARAM_CHECKSUM_EN
            S_CHECK: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (accept) state_next = S_DONE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

`ifdef PARAM_CHECKSUM_EN
    logic [7:0] sum_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_phase_reg  <= 1'b0;
            lo_byte_reg   <= '0;
            tap_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            bias_cnt_reg  <= '0;
            row_buf_reg   <= '0;
            wr_w_en_reg   <= 1'b0;
            wr_b_en_reg   <= 1'b0;
            wr_w_addr_reg <= '0;
            wr_w_data_reg <= '0;
            wr_b_addr_reg <= '0;
            wr_b_data_reg <= '0;
            err_reg       <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            wr_w_en_reg <= 1'b0;
            wr_b_en_reg <= 1'b0;
            if (load_start) begin
                hi_phase_reg <= 1'b0;
                tap_cnt_reg  <= '0;
                row_cnt_reg  <= '0;
                bias_cnt_reg <= '0;
                err_reg      <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
                sum_reg      <= '0;
`endif
            end else if (accept && (state_reg == S_WEIGHT || state_reg == S_BIAS)) begin
`ifdef PARAM_CHECKSUM_EN
                sum_reg <= sum_reg + bus.in_data;
`endif
                hi_phase_reg <= ~hi_phase_reg;
                if (!hi_phase_reg) begin
                    lo_byte_reg <= bus.in_data;
                end else if (state_reg == S_WEIGHT) begin
                    // Taps shift in from the top so tap 0 ends at the bottom of the row.
                    if (tap_last) begin
                        tap_cnt_reg   <= '0;
                        wr_w_en_reg   <= 1'b1;
                        wr_w_addr_reg <= row_cnt_reg;
                        wr_w_data_reg <= {word, row_buf_reg};
                        if (!row_last) row_cnt_reg <= row_cnt_reg + 12'd1;
                    end else begin
                        tap_cnt_reg <= tap_cnt_reg + 4'd1;
                        row_buf_reg <= {word, row_buf_reg[(TAPS-1)*PW-1:PW]};
                    end
                end else begin
                    wr_b_en_reg   <= 1'b1;
                    wr_b_addr_reg <= bias_cnt_reg;
                    wr_b_data_reg <= word;
                    if (!bias_last) bias_cnt_reg <= bias_cnt_reg + 7'd1;
                end
            end
`ifdef PARAM_CHECKSUM_EN
            else if (accept && state_reg == S_CHECK) begin
                err_reg <= (bus.in_data != sum_reg);
            end
`endif
        end
    end

    assign bus.wr_w_en   = wr_w_en_reg;
    assign bus.wr_w_addr = wr_w_addr_reg;
    assign bus.wr_w_data = wr_w_data_reg;
    assign bus.wr_b_en   = wr_b_en_reg;
    assign bus.wr_b_addr = wr_b_addr_reg;
    assign bus.wr_b_data = wr_b_data_reg;

`ifdef PARAM_CHECKSUM_EN
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif
endmodule
